// File: rtl/write_pointer_generation.sv
// write_pointer_generation: write-domain side of the async FIFO.
// Keeps the binary write counter and the registered Gray write pointer, and derives
// registered full, almost-full, fill level and sticky overflow from the synchronized
// read pointer.
// Build option: define FIFO_WRT_OVF_EN to compile in the sticky overflow register;
// otherwise wrt_overflow is tied low and wrt_ovf_clr is ignored.
module write_pointer_generation #(
  parameter int unsigned ADDR_SIZE   = 4,
  parameter int unsigned AFULL_LEVEL = 14
) (
  input  logic                 wrt_clk,
  input  logic                 wrt_rst,
  input  logic                 wrt_ena,
  input  logic [ADDR_SIZE:0]   sync_rd_ptr,
  input  logic                 wrt_ovf_clr,
  output logic                 wrt_inc,
  output logic [ADDR_SIZE-1:0] wrt_addr,
  output logic [ADDR_SIZE:0]   wrt_ptr,
  output logic                 wrt_full,
  output logic                 wrt_almost_full,
  output logic [ADDR_SIZE:0]   wrt_level,
  output logic                 wrt_overflow
);

  localparam logic [ADDR_SIZE:0] AfullLevel = AFULL_LEVEL[ADDR_SIZE:0];

  logic [ADDR_SIZE:0] wrt_bin;
  logic [ADDR_SIZE:0] wrt_bin_nxt;
  logic [ADDR_SIZE:0] wrt_gray_nxt;
  logic [ADDR_SIZE:0] rd_bin_sync;
  logic [ADDR_SIZE:0] level_val;
  logic [ADDR_SIZE:0] full_pat;
  logic               full_val;
  logic               afull_val;

  // A write is accepted only when the FIFO is not already full.
  assign wrt_inc      = wrt_ena & ~wrt_full;
  assign wrt_addr     = wrt_bin[ADDR_SIZE-1:0];
  assign wrt_bin_nxt  = wrt_bin + {{ADDR_SIZE{1'b0}}, wrt_inc};
  assign wrt_gray_nxt = wrt_bin_nxt ^ (wrt_bin_nxt >> 1);

  // Full when the next write pointer is one lap ahead of the read pointer; in Gray
  // code that is the read pointer with its two MSBs inverted.
  assign full_pat = {~sync_rd_ptr[ADDR_SIZE:ADDR_SIZE-1], sync_rd_ptr[ADDR_SIZE-2:0]};
  assign full_val = (wrt_gray_nxt == full_pat);

  // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    rd_bin_sync = '0;
    for (int i = 0; i <= int'(ADDR_SIZE); i++) begin
      rd_bin_sync[i] = ^(sync_rd_ptr >> i);
    end
  end

  // Lagging read pointer makes this an over-estimate, never an under-estimate.
  assign level_val = wrt_bin_nxt - rd_bin_sync;
  assign afull_val = (level_val >= AfullLevel);

  // Pointer and status registers advance together on every write-clock edge.
  always_ff @(posedge wrt_clk or posedge wrt_rst) begin
    if (wrt_rst) begin
      wrt_bin         <= '0;
      wrt_ptr         <= '0;
      wrt_full        <= 1'b0;
      wrt_level       <= '0;
      wrt_almost_full <= 1'b0;
    end else begin
      wrt_bin         <= wrt_bin_nxt;
      wrt_ptr         <= wrt_gray_nxt;
      wrt_full        <= full_val;
      wrt_level       <= level_val;
      wrt_almost_full <= afull_val;
    end
  end

`ifdef FIFO_WRT_OVF_EN
  logic ovf_q;

  // Sticky overflow: a rejected write sets it, and a set beats a coincident clear.
  always_ff @(posedge wrt_clk or posedge wrt_rst) begin
    if (wrt_rst) begin
      ovf_q <= 1'b0;
    end else if (wrt_ena && wrt_full) begin
      ovf_q <= 1'b1;
    end else if (wrt_ovf_clr) begin
      ovf_q <= 1'b0;
    end
  end

  assign wrt_overflow = ovf_q;
`else
  logic unused_ovf_clr;

  assign unused_ovf_clr = wrt_ovf_clr;
  assign wrt_overflow   = 1'b0;
`endif

endmodule

// File: tb/tb_write_pointer_generation.sv
// Directed bench for write_pointer_generation (ADDR_SIZE=4, AFULL_LEVEL=14).
module tb_write_pointer_generation;

  logic       wrt_clk;
  logic       wrt_rst;
  logic       wrt_ena;
  logic [4:0] sync_rd_ptr;
  logic       wrt_ovf_clr;
  logic       wrt_inc;
  logic [3:0] wrt_addr;
  logic [4:0] wrt_ptr;
  logic       wrt_full;
  logic       wrt_almost_full;
  logic [4:0] wrt_level;
  logic       wrt_overflow;

  int checks   = 0;
  int failures = 0;

`ifdef FIFO_WRT_OVF_EN
  localparam logic OvfExp = 1'b1;
`else
  localparam logic OvfExp = 1'b0;
`endif

  write_pointer_generation #(
    .ADDR_SIZE  (4),
    .AFULL_LEVEL(14)
  ) dut (
    .wrt_clk        (wrt_clk),
    .wrt_rst        (wrt_rst),
    .wrt_ena        (wrt_ena),
    .sync_rd_ptr    (sync_rd_ptr),
    .wrt_ovf_clr    (wrt_ovf_clr),
    .wrt_inc        (wrt_inc),
    .wrt_addr       (wrt_addr),
    .wrt_ptr        (wrt_ptr),
    .wrt_full       (wrt_full),
    .wrt_almost_full(wrt_almost_full),
    .wrt_level      (wrt_level),
    .wrt_overflow   (wrt_overflow)
  );

  initial wrt_clk = 1'b0;
  always #5 wrt_clk = ~wrt_clk;

  initial begin
    #100000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge wrt_clk);
    #1;
  endtask

  function automatic logic [4:0] gray(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  logic [4:0] prev_ptr;
  logic [4:0] wr_m;
  logic [4:0] rd_m;

  initial begin
    wrt_rst     = 1'b1;
    wrt_ena     = 1'b0;
    sync_rd_ptr = 5'd0;
    wrt_ovf_clr = 1'b0;
    tick();
    tick();
    check("rst_addr", 32'(wrt_addr), 32'd0);
    check("rst_ptr", 32'(wrt_ptr), 32'd0);
    check("rst_full", 32'(wrt_full), 32'd0);
    check("rst_level", 32'(wrt_level), 32'd0);
    check("rst_afull", 32'(wrt_almost_full), 32'd0);
    check("rst_ovf", 32'(wrt_overflow), 32'd0);
    wrt_rst = 1'b0;

    // Reset mid-burst
    wrt_ena = 1'b1;
    tick(); tick(); tick();
    check("burst_addr", 32'(wrt_addr), 32'd3);
    check("burst_ptr", 32'(wrt_ptr), 32'b00010);
    check("burst_level", 32'(wrt_level), 32'd3);
    #2;
    wrt_rst = 1'b1;
    #1;
    check("async_rst_addr", 32'(wrt_addr), 32'd0);
    check("async_rst_ptr", 32'(wrt_ptr), 32'd0);
    check("async_rst_level", 32'(wrt_level), 32'd0);
    tick();
    check("held_rst_addr", 32'(wrt_addr), 32'd0);
    check("held_rst_ptr", 32'(wrt_ptr), 32'd0);
    wrt_ena = 1'b0;
    wrt_rst = 1'b0;
    #1;
    wrt_ena = 1'b1;
    #1;
    check("post_rst_addr", 32'(wrt_addr), 32'd0);
    check("post_rst_inc", 32'(wrt_inc), 32'd1);

    // Fill with read pointer parked at zero
    for (int k = 1; k <= 16; k++) begin
      tick();
      check($sformatf("fill_level_%0d", k), 32'(wrt_level), 32'(k));
      check($sformatf("fill_afull_%0d", k), 32'(wrt_almost_full), 32'(k >= 14));
      check($sformatf("fill_full_%0d", k), 32'(wrt_full), 32'(k == 16));
    end
    check("fill_ptr", 32'(wrt_ptr), 32'b11000);
    check("fill_addr", 32'(wrt_addr), 32'd0);

    // Overflow
    check("ovf_inc", 32'(wrt_inc), 32'd0);
    tick();
    check("ovf_ptr_hold", 32'(wrt_ptr), 32'b11000);
    check("ovf_full_hold", 32'(wrt_full), 32'd1);
    check("ovf_level_hold", 32'(wrt_level), 32'd16);
    check("ovf_set", 32'(wrt_overflow), 32'(OvfExp));
    wrt_ena     = 1'b0;
    wrt_ovf_clr = 1'b1;
    tick();
    check("ovf_clear", 32'(wrt_overflow), 32'd0);
    wrt_ena = 1'b1;
    tick();
    check("ovf_set_beats_clr", 32'(wrt_overflow), 32'(OvfExp));
    wrt_ena     = 1'b0;
    wrt_ovf_clr = 1'b0;

    // Drain one entry
    sync_rd_ptr = 5'b00001;
    tick();
    check("drain_full", 32'(wrt_full), 32'd0);
    check("drain_level", 32'(wrt_level), 32'd15);
    check("drain_afull", 32'(wrt_almost_full), 32'd1);

    // Simultaneous write and read advance at level 15
    wrt_ena     = 1'b1;
    sync_rd_ptr = gray(5'd2);
    #1;
    check("simul_inc", 32'(wrt_inc), 32'd1);
    tick();
    check("simul_level", 32'(wrt_level), 32'd15);
    check("simul_full", 32'(wrt_full), 32'd0);
    check("simul_ptr", 32'(wrt_ptr), 32'b11001);

    // Wrap: 40 writes, read pointer five entries behind the post-write count
    wr_m = 5'd17;
    for (int k = 0; k < 40; k++) begin
      prev_ptr    = wrt_ptr;
      rd_m        = wr_m + 5'd1 - 5'd5;
      sync_rd_ptr = gray(rd_m);
      tick();
      wr_m = wr_m + 5'd1;
      check($sformatf("wrap_ptr_%0d", k), 32'(wrt_ptr), 32'(gray(wr_m)));
      check($sformatf("wrap_onebit_%0d", k), 32'($countones(wrt_ptr ^ prev_ptr)), 32'd1);
      check($sformatf("wrap_level_%0d", k), 32'(wrt_level), 32'd5);
      check($sformatf("wrap_full_%0d", k), 32'(wrt_full), 32'd0);
      check($sformatf("wrap_addr_%0d", k), 32'(wrt_addr), 32'(wr_m[3:0]));
      if (wr_m == 5'd0) begin
        check("wrap_prev_ptr", 32'(prev_ptr), 32'b10000);
        check("wrap_zero_ptr", 32'(wrt_ptr), 32'b00000);
      end
    end
    wrt_ena = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
